alu4_bcd: RTL and testbench
===========================

Name: alu4_bcd

Overview:
- 4-bit registered ALU: add/subtract with and without carry, multiply, and bitwise logic on two unsigned 4-bit operands.
- The unsigned binary result is converted to a 3-digit packed BCD value (12 bits) for a decimal display path.
- Carry/borrow and signed-overflow flags are also produced.
- Sits between operand/opcode sources (switches or a controller) and a 7-segment/BCD display driver.

Parameters:
- none (operand width fixed at 4; BCD width fixed at 12)

Ports:
- clk       input   1   system clock, rising-edge
- rst_n     input   1   asynchronous active-low reset
- A         input   4   operand A, unsigned (two's complement for overflow flag)
- B         input   4   operand B, unsigned (two's complement for overflow flag)
- CarryIN   input   1   carry-in (ADC) / borrow-in (SBB); ignored by other ops
- opCodeA   input   3   operation select
- CarryOUT  output  1   carry-out (add ops) / borrow-out (sub ops), else 0
- bcd       output  12  result in packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones
- overflow  output  1   signed overflow (add/sub) or product exceeds 4 bits (MULT), else 0

Behaviour:
- Single clock domain. The reset is asynchronous and active-low. rst_n low forces CarryOUT=0, bcd=12'h000, overflow=0 immediately, regardless of clk.
- Inputs are sampled on the rising clk edge. Outputs are registered, so latency is 1 cycle. The outputs hold until the next edge.
- There is no handshake; a new operation is accepted every cycle.
- Opcodes (R = binary result fed to the BCD converter):
- 0 ADD: S = A+B (5-bit). R = S. CarryOUT = S[4]. overflow = signed 4-bit overflow (A[3]==B[3] and S[3]!=A[3]).
- 1 SUB: D = A-B mod 16. R = D. CarryOUT = 1 if A<B (borrow). overflow = signed overflow (A[3]!=B[3] and D[3]!=A[3]).
- 2 MULT: P = A*B (8-bit, max 225). R = P. CarryOUT = 0. overflow = 1 if P>15.
- 3 ADC: S = A+B+CarryIN (5-bit). R = S. CarryOUT = S[4]. overflow as ADD, computed on S[3].
- 4 AND: R = A&B. Both flags 0.
- 5 OR: R = A|B. Both flags 0.
- 6 XOR: R = A^B. Both flags 0.
- 7 SBB: D = A-B-CarryIN mod 16. R = D. CarryOUT = 1 if A < B+CarryIN. overflow = signed overflow of the 4-bit subtraction, same rule as SUB applied to D.
- R is zero-extended to 8 bits and converted to BCD. Maximum R is 225, so the hundreds digit is at most 2 and every digit is always a valid 0–9.
- The BCD value for ADD/ADC includes the carry bit, e.g. 31 shows as 0x031.
- Reset deasserted mid-stream: the first valid result appears after the first clk edge following release.

Decomposition:
- Shared package alu4_pkg holds:
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_ADC=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_SBB=7
  - width constants: 4 for operands, 8 for the result, 12 for BCD
- One combinational sub-module, bin2bcd8: 8-bit binary in, 12-bit packed BCD out, implemented as double-dabble (shift-add-3).
- The top level contains the op mux, flag logic and output registers.

Test Plan:
- Reset: rst_n=0 asserted between clk edges with a prior non-zero result present -> bcd=0x000, CarryOUT=0, overflow=0 immediately; all three hold while rst_n=0 across clk edges.
- ADC (op 3):
  - A=0,B=15,Cin=0 -> bcd 0x015, C=0, V=0
  - A=15,B=15,Cin=1 -> bcd 0x031, C=1, V=0
  - A=7,B=7,Cin=1 -> bcd 0x015, C=0, V=1
- SBB (op 7):
  - A=0,B=15,Cin=0 -> bcd 0x001, C=1, V=0
  - A=15,B=0,Cin=0 -> bcd 0x015, C=0, V=0
  - A=7,B=15,Cin=1 -> bcd 0x007, C=1, V=0
- MULT (op 2):
  - A=15,B=15 -> bcd 0x225, C=0, V=1
  - A=7,B=15 -> bcd 0x105, V=1
  - A=15,B=0 -> bcd 0x000, V=0
  - CarryIN=1 has no effect on any MULT result.
- Logic ops, A=14,B=3:
  - AND (op 4) -> bcd 0x002
  - OR (op 5) -> 0x015
  - XOR (op 6) -> 0x013
  - flags 0 in all three cases.
- ADD/SUB and latency:
  - ADD A=9,B=8 -> bcd 0x017, C=1, V=1
  - SUB A=3,B=5 -> bcd 0x014, C=1, V=0
  - back-to-back opcode changes on consecutive edges: each result appears exactly one cycle after its inputs.

Source files
------------

// File: rtl/alu4_pkg.sv
// alu4_pkg: opcodes and widths shared by the ALU and its BCD converter
package alu4_pkg;
  localparam int OPW  = 4;
  localparam int RW   = 8;
  localparam int BCDW = 12;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SBB = 3'd7;
endpackage

// File: rtl/alu4_bcd_bin2bcd8.sv
// bin2bcd8: combinational 8-bit binary to 3-digit packed BCD via double-dabble
module bin2bcd8
  import alu4_pkg::*;
(
  input  logic [RW-1:0]   bin,
  output logic [BCDW-1:0] bcd
);
  logic [BCDW+RW-1:0] s;
  // shift in one binary bit per step, adding 3 to any digit >= 5 first
  always_comb begin
    s = {{BCDW{1'b0}}, bin};
    for (int i = 0; i < RW; i++) begin
      s[11:8]  = s[11:8]  > 4'd4 ? s[11:8]  + 4'd3 : s[11:8];
      s[15:12] = s[15:12] > 4'd4 ? s[15:12] + 4'd3 : s[15:12];
      s[19:16] = s[19:16] > 4'd4 ? s[19:16] + 4'd3 : s[19:16];
      s = s << 1;
    end
    bcd = s[BCDW+RW-1:RW];
  end
endmodule

// File: rtl/alu4_bcd.sv
// alu4_bcd: registered 4-bit ALU with carry/overflow flags and BCD result
module alu4_bcd
  import alu4_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  input  logic            CarryIN,
  input  logic [2:0]      opCodeA,
  output logic            CarryOUT,
  output logic [BCDW-1:0] bcd,
  output logic            overflow
);
  logic            cin;
  logic [OPW:0]    sum;
  logic [OPW:0]    dif;
  logic [RW-1:0]   prod;
  logic            v_add;
  logic            v_sub;
  logic [RW-1:0]   r;
  logic            c;
  logic            v;
  logic [BCDW-1:0] bcd_next;
  assign cin   = (opCodeA == OP_ADC || opCodeA == OP_SBB) & CarryIN;
  assign sum   = {1'b0, A} + {1'b0, B} + {{OPW{1'b0}}, cin};
  assign dif   = {1'b0, A} - {1'b0, B} - {{OPW{1'b0}}, cin};
  assign prod  = {4'd0, A} * {4'd0, B};
  assign v_add = (A[3] == B[3]) && (sum[3] != A[3]);
  assign v_sub = (A[3] != B[3]) && (dif[3] != A[3]);
  // select the binary result and flags for the current opcode
  always_comb begin
    r = 8'd0;
    c = 1'b0;
    v = 1'b0;
    case (opCodeA)
      OP_ADD, OP_ADC: begin r = {3'd0, sum}; c = sum[4]; v = v_add; end
      OP_SUB, OP_SBB: begin r = {4'd0, dif[3:0]}; c = dif[4]; v = v_sub; end
      OP_MUL:         begin r = prod; v = prod > 8'd15; end
      OP_AND:         r = {4'd0, A & B};
      OP_OR:          r = {4'd0, A | B};
      default:        r = {4'd0, A ^ B};
    endcase
  end
  bin2bcd8 u_bcd (
    .bin(r),
    .bcd(bcd_next)
  );
  // register the result and flags, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CarryOUT <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      CarryOUT <= c;
      bcd      <= bcd_next;
      overflow <= v;
    end
  end
endmodule

// File: tb/tb_alu4_bcd.sv
// tb_alu4_bcd: scoreboard bench for alu4_bcd, expected {C,V,bcd} queued per drive
module tb_alu4_bcd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  A = '0;
  logic [3:0]  B = '0;
  logic        CarryIN = 1'b0;
  logic [2:0]  opCodeA = '0;
  logic        CarryOUT;
  logic [11:0] bcd;
  logic        overflow;
  logic [13:0] q[$];
  int          n_run = 0;
  int          n_fail = 0;
  alu4_bcd dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .CarryIN(CarryIN),
    .opCodeA(opCodeA),
    .CarryOUT(CarryOUT),
    .bcd(bcd),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [13:0] model(input int a, input int b, input int ci, input int op);
    int r, c, v, sa, sb, x;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    c = 0;
    v = 0;
    x = 0;
    case (op)
      0: begin r = a + b; c = r > 15; x = sa + sb; v = x > 7 || x < -8; end
      1: begin r = (a - b + 16) % 16; c = a < b; x = sa - sb; v = x > 7 || x < -8; end
      2: begin r = a * b; v = r > 15; end
      3: begin r = a + b + ci; c = r > 15; x = sa + sb + ci; v = x > 7 || x < -8; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin r = (a - b - ci + 32) % 16; c = a < b + ci; x = sa - sb - ci; v = x > 7 || x < -8; end
    endcase
    return {c[0], v[0], 4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [2:0] op, input logic [13:0] e);
    @(negedge clk);
    A = a;
    B = b;
    CarryIN = ci;
    opCodeA = op;
    q.push_back(e);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
  endtask
  // compare each registered result one cycle after its inputs were sampled
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() != 0) chk($sformatf("op%0d A%0d B%0d", dut.opCodeA, dut.A, dut.B), {CarryOUT, overflow, bcd}, q.pop_front());
  end
  initial begin
    int a, b, ci, op;
    #3;
    chk("rst_init", {CarryOUT, overflow, bcd}, 14'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd0,  4'd15, 1'b0, 3'd3, {2'b00, 12'h015});
    drive(4'd15, 4'd15, 1'b1, 3'd3, {2'b10, 12'h031});
    drive(4'd7,  4'd7,  1'b1, 3'd3, {2'b01, 12'h015});
    drive(4'd0,  4'd15, 1'b0, 3'd7, {2'b10, 12'h001});
    drive(4'd15, 4'd0,  1'b0, 3'd7, {2'b00, 12'h015});
    drive(4'd7,  4'd15, 1'b1, 3'd7, {2'b10, 12'h007});
    drive(4'd15, 4'd15, 1'b0, 3'd2, {2'b01, 12'h225});
    drive(4'd7,  4'd15, 1'b0, 3'd2, {2'b01, 12'h105});
    drive(4'd15, 4'd0,  1'b0, 3'd2, {2'b00, 12'h000});
    drive(4'd15, 4'd15, 1'b1, 3'd2, {2'b01, 12'h225});
    drive(4'd7,  4'd15, 1'b1, 3'd2, {2'b01, 12'h105});
    drive(4'd14, 4'd3,  1'b1, 3'd4, {2'b00, 12'h002});
    drive(4'd14, 4'd3,  1'b1, 3'd5, {2'b00, 12'h015});
    drive(4'd14, 4'd3,  1'b1, 3'd6, {2'b00, 12'h013});
    drive(4'd9,  4'd8,  1'b0, 3'd0, {2'b11, 12'h017});
    drive(4'd3,  4'd5,  1'b0, 3'd1, {2'b10, 12'h014});
    drive(4'd9,  4'd8,  1'b1, 3'd0, {2'b11, 12'h017});
    drive(4'd3,  4'd5,  1'b1, 3'd1, {2'b10, 12'h014});
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(15);
      b = $urandom_range(15);
      ci = $urandom_range(1);
      op = $urandom_range(7);
      drive(4'(a), 4'(b), 1'(ci), 3'(op), model(a, b, ci, op));
    end
    drive(4'd15, 4'd15, 1'b0, 3'd3, {2'b10, 12'h030});
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {CarryOUT, overflow, bcd}, 14'h0);
    A = 4'd15;
    B = 4'd15;
    opCodeA = 3'd2;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {CarryOUT, overflow, bcd}, 14'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd9, 4'd8, 1'b0, 3'd0, {2'b11, 12'h017});
    drive(4'd15, 4'd15, 1'b0, 3'd2, {2'b01, 12'h225});
    drain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
